// File: rtl/tick_bcd_pkg.sv
// Shared BCD constants and the load-digit clamp used by the tick-driven BCD counter.
package tick_bcd_pkg;

  localparam int          BCD_W    = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  BCD_ZERO = 4'd0;

  // Codes A..F on a load are forced to 9 so the register never holds an illegal digit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tick_bcd_counter_if.sv
// Control/data bundle between the counter and its driver (master) / the counter itself (slave).
interface tick_bcd_counter_if
  import tick_bcd_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic                      tick_in;
  logic                      en;
  logic                      up_dn;
  logic                      clr;
  logic                      load;
  logic [BCD_W*DIGITS-1:0]   load_val;
  logic [BCD_W*DIGITS-1:0]   bcd_out;
  logic                      carry;
  logic                      step;

  modport master (
    output tick_in, en, up_dn, clr, load, load_val,
    input  bcd_out, carry, step
  );

  modport slave (
    input  tick_in, en, up_dn, clr, load, load_val,
    output bcd_out, carry, step
  );
endinterface

// File: rtl/bcd_digit.sv
// One combinational BCD digit: increment/decrement with ripple carry and borrow out.
module bcd_digit
  import tick_bcd_pkg::*;
(
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic [BCD_W-1:0] value_i,
  output logic [BCD_W-1:0] value_o,
  output logic             carry_o,
  output logic             borrow_o
);

  assign carry_o  = inc_i & (value_i == BCD_MAX);
  assign borrow_o = dec_i & (value_i == BCD_ZERO);

  always_comb begin
    value_o = value_i;
    if (inc_i) begin
      value_o = carry_o ? BCD_ZERO : value_i + 4'd1;
    end else if (dec_i) begin
      value_o = borrow_o ? BCD_MAX : value_i - 4'd1;
    end
  end

endmodule

// File: rtl/tick_bcd_counter.sv
// Multi-digit BCD up/down counter stepped by rising edges of an asynchronous divided clock.
// Define TICK_BCD_SATURATE_EN to hold at the range limits instead of wrapping.
module tick_bcd_counter
  import tick_bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
)(
  input  logic                  clk,
  input  logic                  rst_n,
  tick_bcd_counter_if.slave     bus
);

  localparam int CNT_W = BCD_W * DIGITS;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   step_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   carry_q, carry_d;

  logic [CNT_W-1:0]       cnt_nxt;
  logic [DIGITS:0]        inc_c;
  logic [DIGITS:0]        dec_c;
  logic                   wrap;

  // Digit 0 receives the unit step; each higher digit is driven by its neighbour's carry/borrow.
  assign inc_c[0] = bus.up_dn;
  assign dec_c[0] = ~bus.up_dn;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .inc_i    (inc_c[g]),
        .dec_i    (dec_c[g]),
        .value_i  (cnt_q[g*BCD_W +: BCD_W]),
        .value_o  (cnt_nxt[g*BCD_W +: BCD_W]),
        .carry_o  (inc_c[g+1]),
        .borrow_o (dec_c[g+1])
      );
    end
  endgenerate

  assign wrap = inc_c[DIGITS] | dec_c[DIGITS];

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.load) begin
      for (int i = 0; i < DIGITS; i++) begin
        cnt_d[i*BCD_W +: BCD_W] = bcd_clamp(bus.load_val[i*BCD_W +: BCD_W]);
      end
    end else if (step_q && bus.en) begin
`ifdef TICK_BCD_SATURATE_EN
      cnt_d   = wrap ? cnt_q : cnt_nxt;
`else
      cnt_d   = cnt_nxt;
`endif
      carry_d = wrap;
    end
  end

  // Synchronizer -> history -> registered rising-edge pulse; counter consumes step one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      step_q  <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.tick_in};
      hist_q  <= sync_q[SYNC_STAGES-1];
      step_q  <= sync_q[SYNC_STAGES-1] & ~hist_q;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign bus.bcd_out = cnt_q;
  assign bus.carry   = carry_q;
  assign bus.step    = step_q;

endmodule
